// File: rtl/binary16_pkg.sv
// Shared binary16 definitions for the vector-length datapath.
// Used by binary16_sum_squares, binary16_sqrt and later stages.
package binary16_pkg;

    localparam int EXP_BIAS   = 15;
    localparam int EXP_MAX    = 31;
    localparam logic [15:0] QNAN = 16'h7E00;
    localparam logic [15:0] PINF = 16'h7C00;

    localparam int GUARD_BITS = 3;
    localparam int LATENCY    = 5;
    localparam int EXP_W      = 7;
    localparam int MANT_W     = 11 + GUARD_BITS;
    localparam int MAX_SHIFT  = 13 + GUARD_BITS;

    typedef struct packed {
        logic signed [EXP_W-1:0] exp;
        logic [MANT_W-1:0]       mant;
        logic                    zero;
        logic                    inf;
        logic                    nan;
    } operand_t;

endpackage

// File: rtl/binary16_square.sv
// Two-stage binary16 squarer: unpack/multiply, then normalize
// the product to 1.m plus guard, round and sticky bits.
module binary16_square
    import binary16_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_n,
    input  logic [14:0] op,
    output operand_t    sq
);

    localparam int KEEP = MANT_W - 1;

    logic [10:0]             sig;
    logic [21:0]             prod;
    logic signed [EXP_W-1:0] exp1;
    logic                    zero1;
    logic                    inf1;
    logic                    nan1;
    operand_t                nxt;

    assign sig = {1'b1, op[9:0]};

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            prod  <= '0;
            exp1  <= '0;
            zero1 <= 1'b0;
            inf1  <= 1'b0;
            nan1  <= 1'b0;
        end else begin
            prod  <= 22'(sig) * 22'(sig);
            exp1  <= $signed({1'b0, op[14:10], 1'b0})
                     - EXP_W'(EXP_BIAS);
            zero1 <= (op[14:10] == 5'd0);
            inf1  <= (op[14:10] == 5'(EXP_MAX))
                     && (op[9:0] == '0);
            nan1  <= (op[14:10] == 5'(EXP_MAX))
                     && (op[9:0] != '0);
        end
    end

    // Product lies in [1,4); bit 21 set means the value is >= 2.
    always_comb begin
        nxt      = '0;
        nxt.zero = zero1;
        nxt.inf  = inf1;
        nxt.nan  = nan1;
        if (prod[21]) begin
            nxt.exp  = exp1 + 7'sd1;
            nxt.mant = {prod[21 -: KEEP], |prod[21-KEEP:0]};
        end else begin
            nxt.exp  = exp1;
            nxt.mant = {prod[20 -: KEEP], |prod[20-KEEP:0]};
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sq <= '0;
        end else begin
            sq <= nxt;
        end
    end

endmodule

// File: rtl/binary16_sum_squares.sv
// Pipelined binary16 dx*dx + dy*dy; squares in S1-S2,
// align in S3, add in S4, round and pack in S5.
module binary16_sum_squares
    import binary16_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_n,
    input  logic [15:0] dx,
    input  logic [15:0] dy,
    input  logic        data_valid_in,
    output logic [15:0] result,
    output logic        data_valid_out,
    output logic        busy
);

    localparam logic signed [EXP_W-1:0] EMAX = EXP_W'(EXP_MAX);

    logic [LATENCY-1:0] vpipe;
    operand_t           x;
    operand_t           y;
    logic               unused_sign;

    assign unused_sign = dx[15] ^ dy[15];

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            vpipe <= '0;
        end else begin
            vpipe <= {vpipe[LATENCY-2:0], data_valid_in};
        end
    end

    assign data_valid_out = vpipe[LATENCY-1];
    assign busy           = |vpipe;

    binary16_square u_sq_x (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .op     (dx[14:0]),
        .sq     (x)
    );

    binary16_square u_sq_y (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .op     (dy[14:0]),
        .sq     (y)
    );

    operand_t                      hi;
    operand_t                      lo;
    logic                          swap;
    logic [EXP_W:0]                diff;
    logic [MANT_W+MAX_SHIFT-1:0]   ext;
    logic [MANT_W-1:0]             lo_m;
    logic                          spec;
    logic [15:0]                   spec_val;

    // A zero operand is always placed low so the other passes through.
    always_comb begin
        swap = x.zero || (!y.zero && (y.exp > x.exp));
        hi   = swap ? y : x;
        lo   = swap ? x : y;
        diff = {hi.exp[EXP_W-1], hi.exp}
               - {lo.exp[EXP_W-1], lo.exp};
        ext  = {lo.mant, MAX_SHIFT'(0)} >> diff;
        if (lo.zero) begin
            lo_m = '0;
        end else if (diff > (EXP_W+1)'(MAX_SHIFT)) begin
            lo_m = MANT_W'(1);
        end else begin
            lo_m = {ext[MANT_W+MAX_SHIFT-1 -: MANT_W-1],
                    ext[MAX_SHIFT] | (|ext[MAX_SHIFT-1:0])};
        end
        spec     = 1'b1;
        spec_val = 16'h0000;
        if (x.nan || y.nan) begin
            spec_val = QNAN;
        end else if (x.inf || y.inf) begin
            spec_val = PINF;
        end else if (!(x.zero && y.zero)) begin
            spec = 1'b0;
        end
    end

    logic signed [EXP_W-1:0] s3_exp;
    logic [MANT_W-1:0]       s3_am;
    logic [MANT_W-1:0]       s3_bm;
    logic                    s3_spec;
    logic [15:0]             s3_val;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            s3_exp  <= '0;
            s3_am   <= '0;
            s3_bm   <= '0;
            s3_spec <= 1'b0;
            s3_val  <= '0;
        end else begin
            s3_exp  <= hi.exp;
            s3_am   <= hi.zero ? '0 : hi.mant;
            s3_bm   <= lo_m;
            s3_spec <= spec;
            s3_val  <= spec_val;
        end
    end

    logic [MANT_W:0] sum;

    assign sum = {1'b0, s3_am} + {1'b0, s3_bm};

    logic signed [EXP_W-1:0] s4_exp;
    logic [MANT_W-1:0]       s4_m;
    logic                    s4_spec;
    logic [15:0]             s4_val;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            s4_exp  <= '0;
            s4_m    <= '0;
            s4_spec <= 1'b0;
            s4_val  <= '0;
        end else begin
            if (sum[MANT_W]) begin
                s4_exp <= s3_exp + 7'sd1;
                s4_m   <= {sum[MANT_W:2], sum[1] | sum[0]};
            end else begin
                s4_exp <= s3_exp;
                s4_m   <= sum[MANT_W-1:0];
            end
            s4_spec <= s3_spec;
            s4_val  <= s3_val;
        end
    end

    logic                    rnd;
    logic [11:0]             rsig;
    logic signed [EXP_W-1:0] rexp;
    logic [9:0]              frac;
    logic [15:0]             packed_res;

    always_comb begin
        rnd  = s4_m[2] & (s4_m[1] | s4_m[0] | s4_m[3]);
        rsig = {1'b0, s4_m[MANT_W-1:GUARD_BITS]} + 12'(rnd);
        if (rsig[11]) begin
            rexp = s4_exp + 7'sd1;
            frac = rsig[10:1];
        end else begin
            rexp = s4_exp;
            frac = rsig[9:0];
        end
        if (s4_spec) begin
            packed_res = s4_val;
        end else if (rexp >= EMAX) begin
            packed_res = PINF;
        end else if (rexp <= 7'sd0) begin
            packed_res = 16'h0000;
        end else begin
            packed_res = {1'b0, rexp[4:0], frac};
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            result <= '0;
        end else begin
            result <= packed_res;
        end
    end

endmodule
